// File: rtl/cegen_pkg.sv
// cegen_pkg: shared definitions for the programmable clock-enable generator.
//   ch_w(n)     : width of a channel index for n channels, at least 1 bit
//   DEF_NUM_CH  : default number of enable channels
//   DEF_DIV_W   : default divisor register width
//   ch_state_t  : per-channel state {div, nxt, pend, cnt} at the default width
package cegen_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIV_W  = 8;

    // Channel index width; a single channel still needs a 1-bit select.
    function automatic int ch_w(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    typedef struct packed {
        logic [DEF_DIV_W-1:0] div;
        logic [DEF_DIV_W-1:0] nxt;
        logic                 pend;
        logic [DEF_DIV_W-1:0] cnt;
    } ch_state_t;

endpackage

// File: rtl/ce_channel.sv
// ce_channel: one programmable enable channel.
//   clk, reset_n : system clock, asynchronous active-low reset
//   run          : global run flag (counting allowed)
//   hold_eff     : effective freeze request (0 when hold support is compiled out)
//   sync         : restart counter at 0
//   wr_hit       : divisor write addressed to this channel
//   wr_div       : new divisor (period-1)
//   ce_p, ce_n   : enables at cnt==0 and cnt==(div+1)>>1
//   pending      : a written divisor is waiting for the period boundary
// The layout mirrors cegen_pkg::ch_state_t, sized by DIV_W here.
module ce_channel
    import cegen_pkg::*;
#(
    parameter int               DIV_W     = DEF_DIV_W,
    parameter logic [DIV_W-1:0] RESET_DIV = {DIV_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             hold_eff,
    input  logic             sync,
    input  logic             wr_hit,
    input  logic [DIV_W-1:0] wr_div,
    output logic             ce_p,
    output logic             ce_n,
    output logic             pending
);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] nxt;
        logic             pend;
        logic [DIV_W-1:0] cnt;
    } state_t;

    state_t           st_r;
    state_t           st_nx_s;
    logic             adv_s;
    logic             term_s;
    logic             apply_s;
    logic [DIV_W:0]   half_s;

    assign adv_s   = run & ~hold_eff;
    assign term_s  = (st_r.cnt == st_r.div);
    // The divisor only changes on an edge that actually closes a period.
    assign apply_s = adv_s & term_s;
    assign half_s  = ({1'b0, st_r.div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

    // Next-state: pending capture, boundary apply, counter advance.
    always_comb begin
        st_nx_s = st_r;
        if (wr_hit) begin
            st_nx_s.nxt = wr_div;
        end else begin
            st_nx_s.nxt = st_r.nxt;
        end
        if (apply_s) begin
            // A write landing on the terminal edge takes effect directly.
            if (wr_hit) begin
                st_nx_s.div = wr_div;
            end else if (st_r.pend) begin
                st_nx_s.div = st_r.nxt;
            end else begin
                st_nx_s.div = st_r.div;
            end
            st_nx_s.pend = 1'b0;
        end else if (wr_hit) begin
            st_nx_s.pend = 1'b1;
        end else begin
            st_nx_s.pend = st_r.pend;
        end
        if (sync) begin
            st_nx_s.cnt = {DIV_W{1'b0}};
        end else if (adv_s) begin
            if (term_s) begin
                st_nx_s.cnt = {DIV_W{1'b0}};
            end else begin
                st_nx_s.cnt = st_r.cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            st_nx_s.cnt = st_r.cnt;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_r.div  <= RESET_DIV;
            st_r.nxt  <= RESET_DIV;
            st_r.pend <= 1'b0;
            st_r.cnt  <= {DIV_W{1'b0}};
        end else begin
            st_r <= st_nx_s;
        end
    end

    // Enables decode registered state; only hold reaches them combinationally.
    assign ce_p    = adv_s & (st_r.cnt == {DIV_W{1'b0}});
    assign ce_n    = adv_s & (st_r.div != {DIV_W{1'b0}}) & ({1'b0, st_r.cnt} == half_s);
    assign pending = st_r.pend;

endmodule

// File: rtl/ce_generator_prog.sv
// ce_generator_prog: NUM_CH independent clock-enable pairs with runtime
// divisors applied at period boundaries.
//   clk, reset_n : system clock, asynchronous active-low reset
//   wr_en/wr_ch/wr_div : single-cycle divisor write (out-of-range wr_ch ignored)
//   sync         : restart all channel counters
//   hold         : freeze all channels; functional only when the macro
//                  CEGEN_HOLD_EN is defined, otherwise ignored
//   ce_p, ce_n, pending : per-channel outputs
module ce_generator_prog
    import cegen_pkg::*;
#(
    parameter int                      NUM_CH    = DEF_NUM_CH,
    parameter int                      DIV_W     = DEF_DIV_W,
    parameter logic [NUM_CH*DIV_W-1:0] RESET_DIV = {8'd63, 8'd15, 8'd15, 8'd3}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
    input  logic [DIV_W-1:0]          wr_div,
    input  logic                      sync,
    input  logic                      hold,
    output logic [NUM_CH-1:0]         ce_p,
    output logic [NUM_CH-1:0]         ce_n,
    output logic [NUM_CH-1:0]         pending
);

    localparam int CH_W = ch_w(NUM_CH);

    logic              run_r;
    logic              hold_eff_s;
    logic [NUM_CH-1:0] wr_hit_s;

`ifdef CEGEN_HOLD_EN
    assign hold_eff_s = hold;
`else
    logic unused_hold_s;
    assign hold_eff_s    = 1'b0;
    assign unused_hold_s = hold;
`endif

    // Run flag: set on the first edge after reset release so no channel
    // emits a partial pulse out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            // Indices >= NUM_CH never match, so such writes are dropped.
            assign wr_hit_s[i] = wr_en & (wr_ch == CH_W'(i));

            ce_channel #(
                .DIV_W     (DIV_W),
                .RESET_DIV (RESET_DIV[i*DIV_W +: DIV_W])
            ) u_ch (
                .clk      (clk),
                .reset_n  (reset_n),
                .run      (run_r),
                .hold_eff (hold_eff_s),
                .sync     (sync),
                .wr_hit   (wr_hit_s[i]),
                .wr_div   (wr_div),
                .ce_p     (ce_p[i]),
                .ce_n     (ce_n[i]),
                .pending  (pending[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ce_generator_prog.sv
// Self-checking bench for ce_generator_prog (default 4 channels, 8-bit divisors,
// reset divisors ch3..ch0 = 63,15,15,3). Cycle n is the cycle after the n-th
// clock edge following reset release; inputs are driven 1 time unit after the
// rising edge and outputs sampled on the falling edge.
module tb_ce_generator_prog;

`ifdef CEGEN_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic       sync;
    logic       hold;
    logic [3:0] ce_p;
    logic [3:0] ce_n;
    logic [3:0] pending;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [7:0] dv;
        logic       sy;
        logic [3:0] exp_p;
        logic [3:0] exp_n;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t tv[$];

    ce_generator_prog dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .sync    (sync),
        .hold    (hold),
        .ce_p    (ce_p),
        .ce_n    (ce_n),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] p, input logic [3:0] n,
                           input logic [3:0] pd);
        chk({tag, ".ce_p"}, ce_p, p);
        chk({tag, ".ce_n"}, ce_n, n);
        chk({tag, ".pending"}, pending, pd);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        wr_en = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) next_cycle();
    endtask

    task automatic add(input logic we, input logic [1:0] ch, input logic [7:0] dv,
                       input logic sy, input logic [3:0] p, input logic [3:0] n,
                       input logic [3:0] pd);
        vec_t v;
        v.we = we; v.ch = ch; v.dv = dv; v.sy = sy;
        v.exp_p = p; v.exp_n = n; v.exp_pend = pd;
        tv.push_back(v);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        reset_n = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_div = 8'd0;
        sync = 1'b0; hold = 1'b0;

        // Cycles 1..30: ch0 rewritten to 7 mid-period, ch1 written 5 then 9,
        // ch2 written 0 on its terminal edge (bypass, then ce_p every cycle).
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b1111, 4'b0000, 4'b0000); // 1
        add(1'b1, 2'd0, 8'd7, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 2
        add(1'b1, 2'd1, 8'd5, 1'b0, 4'b0000, 4'b0001, 4'b0001); // 3
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0011); // 4
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 4'b0000, 4'b0010); // 5
        add(1'b1, 2'd1, 8'd9, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 6
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 7
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 8
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0111, 4'b0010); // 9
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 10
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 11
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 12
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 4'b0000, 4'b0010); // 13
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 14
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 15
        add(1'b1, 2'd2, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0010); // 16
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0110, 4'b0001, 4'b0000); // 17
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 18
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 19
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 20
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0101, 4'b0000, 4'b0000); // 21
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0010, 4'b0000); // 22
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 23
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 24
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0001, 4'b0000); // 25
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 26
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0110, 4'b0000, 4'b0000); // 27
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 28
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0101, 4'b0000, 4'b0000); // 29
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000); // 30

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000);

        // Release; cycle 0 (run still 0) must be quiet.
        reset_n = 1'b1;
        cyc = 0;
        @(negedge clk);
        chk_all("cycle0", 4'b0000, 4'b0000, 4'b0000);

        foreach (tv[k]) begin
            next_cycle();
            wr_en  = tv[k].we;
            wr_ch  = tv[k].ch;
            wr_div = tv[k].dv;
            sync   = tv[k].sy;
            @(negedge clk);
            chk_all($sformatf("vec%0d", k + 1), tv[k].exp_p, tv[k].exp_n, tv[k].exp_pend);
        end

        // ch3 (div 63): ce_n at cycle 33, ce_p again at cycle 65.
        goto_cycle(33);
        @(negedge clk);
        chk_all("c33", 4'b0100, 4'b1001, 4'b0000);
        goto_cycle(65);
        @(negedge clk);
        chk_all("c65", 4'b1100, 4'b0001, 4'b0000);

        // sync at cycle 66 with channels at mixed counts.
        next_cycle();
        sync = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_all("sync", 4'b1111, 4'b0000, 4'b0000);

        // hold for cycles 68..72; a write during hold is still accepted.
        next_cycle();
        hold = 1'b1;
        @(negedge clk);
        chk_all("hold68", HOLD_EN ? 4'b0000 : 4'b0100, 4'b0000, 4'b0000);
        next_cycle();
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd1;
        next_cycle();
        @(negedge clk);
        chk("hold_wr.pending", pending, 4'b1000);
        next_cycle();
        @(negedge clk);
        chk("hold71.ce_n", ce_n, HOLD_EN ? 4'b0000 : 4'b0001);
        chk("hold71.ce_p", ce_p, HOLD_EN ? 4'b0000 : 4'b0100);
        next_cycle();
        next_cycle();
        hold = 1'b0;
        goto_cycle(76);
        @(negedge clk);
        chk_all("resume76", 4'b0100, HOLD_EN ? 4'b0001 : 4'b0000, 4'b1000);
        goto_cycle(80);
        @(negedge clk);
        chk_all("resume80", HOLD_EN ? 4'b0101 : 4'b0100, 4'b0000, 4'b1000);

        // Asynchronous reset mid-period clears everything at once.
        next_cycle();
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        @(negedge clk);
        chk_all("rerelease0", 4'b0000, 4'b0000, 4'b0000);
        next_cycle();
        @(negedge clk);
        chk_all("rerelease1", 4'b1111, 4'b0000, 4'b0000);
        goto_cycle(3);
        @(negedge clk);
        chk_all("rerelease3", 4'b0000, 4'b0001, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
